// File: rtl/ysyx_23060077_ibuf.sv
// Instruction buffer between IFU and IDU: a DEPTH-entry circular FIFO of {pc, inst}
// pairs with predecode computed on enqueue and a valid/ready handshake on both sides.
module ysyx_23060077_ibuf #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int PRE_WIDTH  = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [INST_WIDTH-1:0]      in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic [PRE_WIDTH-1:0]       out_predecode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam int PRE_JAL    = 0;
  localparam int PRE_JALR   = 1;
  localparam int PRE_BRANCH = 2;
  localparam int PRE_SYS    = 3;
  localparam int PRE_ECALL  = 4;
  localparam int PRE_MRET   = 5;

  function automatic logic [PRE_WIDTH-1:0] predecode(input logic [INST_WIDTH-1:0] inst);
    logic [PRE_WIDTH-1:0] pre;
    pre             = '0;
    pre[PRE_JAL]    = (inst[6:0] == 7'b1101111);
    pre[PRE_JALR]   = (inst[6:0] == 7'b1100111);
    pre[PRE_BRANCH] = (inst[6:0] == 7'b1100011);
    pre[PRE_SYS]    = (inst[6:0] == 7'b1110011);
    pre[PRE_ECALL]  = (inst == INST_WIDTH'(32'h0000_0073));
    pre[PRE_MRET]   = (inst == INST_WIDTH'(32'h3020_0073));
    return pre;
  endfunction

  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PRE_WIDTH-1:0]  mem_pre  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;

  // Handshake flags depend only on the registered count, so a full buffer never
  // accepts even when the head is consumed in the same cycle.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  assign out_pc        = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_inst      = out_valid ? mem_inst[rd_ptr] : '0;
  assign out_predecode = out_valid ? mem_pre[rd_ptr]  : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; out_valid masks stale contents.
  always_ff @(posedge clock) begin
    if (enq && !flush) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_inst[wr_ptr] <= in_inst;
      mem_pre[wr_ptr]  <= predecode(in_inst);
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_ibuf.sv
// Directed bench for the instruction buffer: fill/drain, streaming with wrap,
// predecode values, flush and asynchronous reset.
module tb_ysyx_23060077_ibuf;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [5:0]  out_predecode;
  logic [2:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ysyx_23060077_ibuf #(
    .DEPTH(4), .PC_WIDTH(32), .INST_WIDTH(32), .PRE_WIDTH(6)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_predecode(out_predecode), .count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (count !== 3'd0) $display("FAIL reset_count: got %0d required 0", count);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_inst !== 32'h0) $display("FAIL reset_out_inst: got %h required 0", out_inst);
    else pass_cnt++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_first_entry();
    in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_006F;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL first_valid: got %b required 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_inst !== 32'h0000_006F) $display("FAIL first_inst: got %h required 0000006f", out_inst);
    else pass_cnt++;
    total_cnt++;
    if (out_pc !== 32'h8000_0000) $display("FAIL first_pc: got %h required 80000000", out_pc);
    else pass_cnt++;
    total_cnt++;
    if (out_predecode !== 6'h01) $display("FAIL first_predecode: got %h required 01", out_predecode);
    else pass_cnt++;
    total_cnt++;
    if (count !== 3'd1) $display("FAIL first_count: got %0d required 1", count);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL first_drain: got count %0d valid %b required 0 0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_inst   = 32'h0010_0513;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i);
      step();
    end
    total_cnt++;
    if (count !== 3'd4) $display("FAIL full_count: got %0d required 4", count);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b required 0", in_ready);
    else pass_cnt++;
    // Fifth offer, no dequeue: must be dropped.
    in_pc = 32'h200;
    step();
    total_cnt++;
    if (count !== 3'd4) $display("FAIL full_fifth_ignored: got %0d required 4", count);
    else pass_cnt++;
    // Offer again while consuming the head: still no pass-through.
    out_ready = 1'b1;
    total_cnt++;
    if (out_pc !== 32'h100) $display("FAIL full_drain_pc0: got %h required 00000100", out_pc);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd3) $display("FAIL full_no_passthrough: got %0d required 3", count);
    else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      total_cnt++;
      if (out_pc !== 32'h100 + 32'(4 * i))
        $display("FAIL full_drain_pc%0d: got %h required %h", i, out_pc, 32'h100 + 32'(4 * i));
      else pass_cnt++;
      step();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL full_empty: got count %0d valid %b required 0 0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    in_inst = 32'h0000_0013;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * i);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'h308 + 32'(4 * k);
      total_cnt++;
      if (out_pc !== 32'h300 + 32'(4 * k) || count !== 3'd2)
        $display("FAIL stream_%0d: got pc %h count %0d required pc %h count 2",
                 k, out_pc, count, 32'h300 + 32'(4 * k));
      else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      total_cnt++;
      if (out_pc !== 32'h300 + 32'(4 * k))
        $display("FAIL stream_tail_%0d: got %h required %h", k, out_pc, 32'h300 + 32'(4 * k));
      else pass_cnt++;
      step();
    end
    out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0) $display("FAIL stream_empty: got %0d required 0", count);
    else pass_cnt++;
  endtask

  task automatic test_predecode();
    logic [31:0] insts [6];
    logic [5:0]  pres  [6];
    insts = '{32'h0000_0073, 32'h3020_0073, 32'h0010_0513,
              32'h0000_8067, 32'h0000_0463, 32'h3052_9073};
    // bit0 JAL, bit1 JALR, bit2 BRANCH, bit3 SYS, bit4 ECALL, bit5 MRET
    pres  = '{6'h18, 6'h28, 6'h00, 6'h02, 6'h04, 6'h08};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * i); in_inst = insts[i];
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_predecode !== pres[i] || out_inst !== insts[i])
        $display("FAIL predecode_%0d: got pre %h inst %h required pre %h inst %h",
                 i, out_predecode, out_inst, pres[i], insts[i]);
      else pass_cnt++;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_flush();
    in_inst = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i);
      step();
    end
    total_cnt++;
    if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d required 3", count);
    else pass_cnt++;
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h500; in_inst = 32'hDEAD_BEEF;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0)
      $display("FAIL flush_empty: got count %0d valid %b ready %b inst %h required 0 0 1 0",
               count, out_valid, in_ready, out_inst);
    else pass_cnt++;
    in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h0000_006F;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_pc !== 32'h600 || out_inst !== 32'h0000_006F || count !== 3'd1)
      $display("FAIL flush_next: got pc %h inst %h count %0d required 00000600 0000006f 1",
               out_pc, out_inst, count);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_inst = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h800 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd3) $display("FAIL areset_pre_count: got %0d required 3", count);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL areset_immediate: got count %0d valid %b required 0 0", count, out_valid);
    else pass_cnt++;
    #2;
    reset_n = 1'b1;
    step();
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL areset_after: got count %0d valid %b ready %b required 0 0 1",
               count, out_valid, in_ready);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #1;
    test_reset();
    test_first_entry();
    test_full();
    test_back_to_back();
    test_predecode();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
